uart_tx_feeder: RTL and testbench

Transmit-side buffer and launcher that sits directly upstream of `uart_tx`. It accepts bytes from the APB register block into a synchronous FIFO and hands them to `uart_tx` one at a time. For each byte it issues a single-cycle `tx_en` with stable data and waits for `tx_done` before launching the next. It also provides fill-level status, a sticky overflow flag and a threshold interrupt for the APB side.

---
 rtl/uart_tx_feeder.sv | 113 +++++++++++
 tb/tb_uart_tx_feeder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Transmit FIFO and launcher feeding uart_tx: one tx_en pulse per byte, next
// byte only after tx_done. Provides fill level, sticky overflow and threshold irq.
module uart_tx_feeder #(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned THRESH = 4,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_enable,
    input  logic          flush,
    input  logic          ovf_clr,
    input  logic          tx_busy,
    input  logic          tx_done,
    output logic          tx_en,
    output logic [7:0]    tx_data_out,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          tx_irq
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ovf_q, ovf_d;
    logic          wr_accept, wr_drop, pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign tx_irq = (32'(count_q) <= THRESH);

    assign wr_accept = wr_en && !full && !flush;
    assign wr_drop   = wr_en && full && !flush;
    assign pop       = (state_q == S_IDLE) && tx_enable && !empty && !tx_busy && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop) state_d = S_LAUNCH;
            S_LAUNCH:    state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (tx_done) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_accept && !pop)      count_d = count_q + 1'b1;
            else if (!wr_accept && pop) count_d = count_q - 1'b1;
        end
    end

    // tx_en is registered from the pop decision, so it is high exactly in LAUNCH.
    always_comb begin
        tx_en_d   = pop;
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
        ovf_d     = ovf_q;
        if (wr_drop)      ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx_en       = tx_en_q;
    assign tx_data_out = tx_data_q;
    assign count       = count_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: queue-based reference model, uart_tx stub
// and a negedge monitor comparing every cycle against the model.
module tb_uart_tx_feeder;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 4;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          arst_n    = 1'b1;
    logic          wr_en     = 1'b0;
    logic [7:0]    wr_data   = 8'h00;
    logic          tx_enable = 1'b0;
    logic          flush     = 1'b0;
    logic          ovf_clr   = 1'b0;
    logic          tx_busy   = 1'b0;
    logic          tx_done   = 1'b0;
    logic          tx_en;
    logic [7:0]    tx_data_out;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_irq;

    uart_tx_feeder #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk(clk), .arst_n(arst_n), .wr_en(wr_en), .wr_data(wr_data),
        .tx_enable(tx_enable), .flush(flush), .ovf_clr(ovf_clr),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_en(tx_en),
        .tx_data_out(tx_data_out), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: mq is the byte queue, sb holds bytes the DUT should be launching.
    byte unsigned mq[$];
    byte unsigned sb[$];
    byte unsigned launched[$];
    int           en_cyc[$];
    int           done_cyc[$];
    int           fly    = 0;   // 0: nothing in flight, 1: launch cycle, 2: awaiting tx_done
    bit           ovf_m  = 1'b0;
    byte unsigned last_m = 8'h00;
    int           same_m = 0;
    bit           m_pop, m_acc;
    byte unsigned exp1[3] = '{8'h55, 8'hA3, 8'h0F};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mq.delete();
            sb.delete();
            fly    = 0;
            ovf_m  = 1'b0;
            last_m = 8'h00;
        end else begin
            m_pop = (fly == 0) && tx_enable && (mq.size() > 0) && !tx_busy && !flush;
            m_acc = wr_en && (mq.size() < DEPTH) && !flush;
            if (wr_en && mq.size() == DEPTH && !flush) ovf_m = 1'b1;
            else if (ovf_clr)                          ovf_m = 1'b0;
            if (fly == 1)                   fly = 2;
            else if (fly == 2 && tx_done)   fly = 0;
            else if (fly == 0 && m_pop)     fly = 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) begin
                    last_m = mq.pop_front();
                    sb.push_back(last_m);
                end
                if (m_acc) mq.push_back(wr_data);
                if (m_pop && m_acc) same_m++;
            end
        end
    end

    always @(negedge clk) begin
        chk("tx_en", int'(tx_en), int'(fly == 1));
        if (tx_en === 1'b1) begin
            launched.push_back(tx_data_out);
            en_cyc.push_back(cyc);
            chk("launch_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("launch_data", int'(tx_data_out), int'(sb.pop_front()));
        end
        chk("data_hold", int'(tx_data_out), int'(last_m));
        chk("count", int'(count), mq.size());
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("empty", int'(empty), int'(mq.size() == 0));
        chk("tx_irq", int'(tx_irq), int'(mq.size() <= THRESH));
        chk("overflow", int'(overflow), int'(ovf_m));
    end

    // uart_tx stub: busy for 20 cycles after each launch, then a one-cycle tx_done.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                tx_busy = 1'b1;
                repeat (20) @(negedge clk);
                tx_busy = 1'b0;
                tx_done = 1'b1;
                done_cyc.push_back(cyc);
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic drv(input bit w, input byte unsigned d, input bit f, input bit oc);
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        flush   = f;
        ovf_clr = oc;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() > 0 || fly != 0 || tx_busy || tx_done) && n < budget) begin
            drv(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk("drain_in_budget", int'(n < budget), 1);
    endtask

    task automatic wait_state(input int want_fly, input int want_size, input string name);
        int n = 0;
        while (!(fly == want_fly && mq.size() == want_size) && n < 100) begin
            drv(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        chk(name, int'(n < 100), 1);
    endtask

    initial begin
        int           n, nb, ee;
        bit           pp, w;
        byte unsigned hold;

        #1 arst_n = 1'b0;
        #11;
        chk("rst_tx_en", int'(tx_en), 0);
        chk("rst_data", int'(tx_data_out), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_irq", int'(tx_irq), 1);
        #10 arst_n = 1'b1;

        // Three bytes, back-to-back frames
        tx_enable = 1'b1;
        drv(1'b1, 8'h55, 1'b0, 1'b0);
        drv(1'b1, 8'hA3, 1'b0, 1'b0);
        drv(1'b1, 8'h0F, 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        drain(300);
        chk("t1_launches", launched.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t1_byte", (i < launched.size()) ? int'(launched[i]) : -1, int'(exp1[i]));
        for (int i = 1; i < 3; i++)
            chk("t1_gap", (i < en_cyc.size() && i - 1 < done_cyc.size()) ?
                en_cyc[i] - done_cyc[i-1] : -1, 2);
        chk("t1_count_end", int'(count), 0);

        // Fill past DEPTH with launches disabled
        tx_enable = 1'b0;
        launched.delete();
        for (int i = 0; i < 16; i++) drv(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drv(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t2_full", int'(full), 1);
        chk("t2_no_ovf_yet", int'(overflow), 0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_overflow", int'(overflow), 1);
        chk("t2_count16", int'(count), 16);
        drv(1'b0, 8'h00, 1'b0, 1'b1);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t2_ovf_clr", int'(overflow), 0);
        tx_enable = 1'b1;
        drain(1000);
        chk("t2_launches", launched.size(), 16);
        ee = 0;
        foreach (launched[i]) if (launched[i] == 8'hEE) ee++;
        chk("t2_no_17th", ee, 0);

        // Writes coinciding with pops, 40 bytes through the pointer wrap
        same_m = 0;
        n = 0;
        nb = 0;
        while (n < 40 && nb < 3000) begin
            @(negedge clk);
            nb++;
            pp = (fly == 0) && tx_enable && (mq.size() > 0) && !tx_busy;
            w  = (pp || $urandom_range(0, 19) == 0) && (mq.size() < DEPTH - 1);
            wr_en   = w;
            wr_data = 8'($urandom);
            if (w) n++;
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t3_writes", n, 40);
        drain(800);
        chk("t3_same_cycle", int'(same_m > 0), 1);

        // Flush with 5 queued while a byte is in flight
        launched.delete();
        for (int i = 0; i < 6; i++) drv(1'b1, 8'($urandom), 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        wait_state(2, 5, "t4_setup");
        nb   = launched.size();
        hold = tx_data_out;
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_count0", int'(count), 0);
        chk("t4_hold", int'(tx_data_out), int'(hold));
        drain(100);
        repeat (10) drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_no_more_launch", launched.size(), nb);

        // Threshold crossing while draining
        tx_enable = 1'b0;
        for (int i = 0; i < 6; i++) drv(1'b1, 8'($urandom), 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5_count6", int'(count), 6);
        chk("t5_irq6", int'(tx_irq), 0);
        tx_enable = 1'b1;
        wait_state(fly == 0 ? 1 : fly, 5, "t5_reach5");
        chk("t5_count5", int'(count), 5);
        chk("t5_irq5", int'(tx_irq), 0);
        wait_state(1, 4, "t5_reach4");
        chk("t5_count4", int'(count), 4);
        chk("t5_irq4", int'(tx_irq), 1);
        drain(400);

        // Reset during WAIT_DONE with 3 queued
        for (int i = 0; i < 4; i++) drv(1'b1, 8'($urandom), 1'b0, 1'b0);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        wait_state(2, 3, "t6_setup");
        #2 arst_n = 1'b0;
        #1;
        chk("t6_tx_en", int'(tx_en), 0);
        chk("t6_data", int'(tx_data_out), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_full", int'(full), 0);
        chk("t6_overflow", int'(overflow), 0);
        chk("t6_irq", int'(tx_irq), 1);
        repeat (3) drv(1'b0, 8'h00, 1'b0, 1'b0);
        #2 arst_n = 1'b1;
        nb = launched.size();
        repeat (60) drv(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_no_launch", launched.size(), nb);

        // Randomized traffic with enable toggling, flushes and overflow clears
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) tx_enable = ~tx_enable;
            drv($urandom_range(0, 3) == 0, 8'($urandom),
                $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
        end
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        tx_enable = 1'b1;
        drain(1000);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
